// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control FSM.
// MC_ILLEGAL_TRAP_EN adds the HALT state used to trap undefined instructions.
package mc_ctrl_pkg;

  localparam int unsigned OP_W     = 6;
  localparam int unsigned ALU_OP_W = 3;

  // Primary opcodes (IR[31:26]) and R-type function codes (IR[5:0])
  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_ADDIU = 6'h09;
  localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
  localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;
  localparam logic [OP_W-1:0] FN_ADDU  = 6'h21;
  localparam logic [OP_W-1:0] FN_SUBU  = 6'h23;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'd1;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'd2;
  localparam logic [ALU_OP_W-1:0] ALU_LUI = 3'd3;

  // One-hot datapath mux selects; all-zero is never a legal value
  localparam logic [1:0] NPC_ALU      = 2'b01;
  localparam logic [1:0] NPC_JMP      = 2'b10;
  localparam logic [1:0] ADDR_PC      = 2'b01;
  localparam logic [1:0] ADDR_ALUOUT  = 2'b10;
  localparam logic [1:0] ALUA_PC      = 2'b01;
  localparam logic [1:0] ALUA_RS      = 2'b10;
  localparam logic [3:0] ALUB_RT      = 4'b0001;
  localparam logic [3:0] ALUB_FOUR    = 4'b0010;
  localparam logic [3:0] ALUB_SEXT    = 4'b0100;
  localparam logic [3:0] ALUB_ZEXT    = 4'b1000;
  localparam logic [1:0] WDATA_ALUOUT = 2'b01;
  localparam logic [1:0] WDATA_MDR    = 2'b10;
  localparam logic [1:0] WREG_RT      = 2'b01;
  localparam logic [1:0] WREG_RD      = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXE_R,
    S_EXE_I,
    S_WB_REG,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_BRANCH,
    S_JUMP
`ifdef MC_ILLEGAL_TRAP_EN
    , S_HALT
`endif
  } state_t;

  // Where DECODE goes for an undefined instruction
`ifdef MC_ILLEGAL_TRAP_EN
  localparam state_t S_ILLEGAL_NEXT = S_HALT;
`else
  localparam state_t S_ILLEGAL_NEXT = S_FETCH;
`endif

  typedef enum logic [3:0] {
    CLS_ADDU,
    CLS_SUBU,
    CLS_ORI,
    CLS_LUI,
    CLS_ADDIU,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_J,
    CLS_ILLEGAL
  } cls_t;

  typedef struct packed {
    logic                pc_we;
    logic                ir_we;
    logic                gpr_we;
    logic                dmem_we;
    logic [1:0]          npc_sel;
    logic [1:0]          sel_addr;
    logic [1:0]          sel_alua;
    logic [3:0]          sel_alub;
    logic [1:0]          sel_wdata;
    logic [1:0]          sel_wreg;
    logic [ALU_OP_W-1:0] alu_op;
  } ctrl_t;

  // Quiescent control word: no writes, every mux on a valid leg
  localparam ctrl_t CTRL_IDLE = '{
    pc_we:     1'b0,
    ir_we:     1'b0,
    gpr_we:    1'b0,
    dmem_we:   1'b0,
    npc_sel:   NPC_ALU,
    sel_addr:  ADDR_PC,
    sel_alua:  ALUA_PC,
    sel_alub:  ALUB_FOUR,
    sel_wdata: WDATA_ALUOUT,
    sel_wreg:  WREG_RT,
    alu_op:    ALU_ADD
  };

  function automatic logic is_rtype(input cls_t c);
    return (c == CLS_ADDU) || (c == CLS_SUBU);
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational classifier: op/funct -> instruction class for the DECODE step.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [OP_W-1:0] op,
  input  logic [OP_W-1:0] funct,
  output cls_t            cls_c
);

  always_comb begin
    cls_c = CLS_ILLEGAL;
    case (op)
      OP_RTYPE: begin
        if (funct == FN_ADDU)      cls_c = CLS_ADDU;
        else if (funct == FN_SUBU) cls_c = CLS_SUBU;
        else                       cls_c = CLS_ILLEGAL;
      end
      OP_ORI:   cls_c = CLS_ORI;
      OP_LUI:   cls_c = CLS_LUI;
      OP_ADDIU: cls_c = CLS_ADDIU;
      OP_LW:    cls_c = CLS_LW;
      OP_SW:    cls_c = CLS_SW;
      OP_BEQ:   cls_c = CLS_BEQ;
      OP_J:     cls_c = CLS_J;
      default:  cls_c = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control FSM for a MIPS-subset datapath.
// Define MC_ILLEGAL_TRAP_EN to trap undefined instructions in a sticky HALT state.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [OP_W-1:0]     op,
  input  logic [OP_W-1:0]     funct,
  input  logic                zero,
  output logic                pc_we,
  output logic                ir_we,
  output logic                gpr_we,
  output logic                dmem_we,
  output logic [1:0]          npc_sel,
  output logic [1:0]          sel_addr,
  output logic [1:0]          sel_alua,
  output logic [3:0]          sel_alub,
  output logic [1:0]          sel_wdata,
  output logic [1:0]          sel_wreg,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                illegal
);

  state_t state;
  cls_t   cls;
  cls_t   dec_cls;
  ctrl_t  ctrl;

  mc_decode u_decode (
    .op    (op),
    .funct (funct),
    .cls_c (dec_cls)
  );

  // State register; the instruction class is captured once in DECODE so later
  // steps never look at op/funct again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
      cls   <= CLS_ILLEGAL;
    end else begin
      case (state)
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          cls <= dec_cls;
          case (dec_cls)
            CLS_ADDU, CLS_SUBU:          state <= S_EXE_R;
            CLS_ORI, CLS_LUI, CLS_ADDIU: state <= S_EXE_I;
            CLS_LW, CLS_SW:              state <= S_MEM_ADDR;
            CLS_BEQ:                     state <= S_BRANCH;
            CLS_J:                       state <= S_JUMP;
            default:                     state <= S_ILLEGAL_NEXT;
          endcase
        end
        S_EXE_R:    state <= S_WB_REG;
        S_EXE_I:    state <= S_WB_REG;
        S_WB_REG:   state <= S_FETCH;
        S_MEM_ADDR: state <= (cls == CLS_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   state <= S_MEM_WB;
        S_MEM_WB:   state <= S_FETCH;
        S_MEM_WR:   state <= S_FETCH;
        S_BRANCH:   state <= S_FETCH;
        S_JUMP:     state <= S_FETCH;
`ifdef MC_ILLEGAL_TRAP_EN
        S_HALT:     state <= S_HALT;
`endif
        default:    state <= S_FETCH;
      endcase
    end
  end

  // Control word decoded from the state register (and captured class) only
  always_comb begin
    ctrl = CTRL_IDLE;
    case (state)
      S_FETCH: begin
        ctrl.ir_we    = 1'b1;
        ctrl.pc_we    = 1'b1;
        ctrl.sel_addr = ADDR_PC;
        ctrl.sel_alua = ALUA_PC;
        ctrl.sel_alub = ALUB_FOUR;
        ctrl.alu_op   = ALU_ADD;
        ctrl.npc_sel  = NPC_ALU;
      end
      S_EXE_R: begin
        ctrl.sel_alua = ALUA_RS;
        ctrl.sel_alub = ALUB_RT;
        ctrl.alu_op   = (cls == CLS_SUBU) ? ALU_SUB : ALU_ADD;
        ctrl.sel_wreg = WREG_RD;
      end
      S_EXE_I: begin
        ctrl.sel_alua = ALUA_RS;
        ctrl.sel_alub = (cls == CLS_ADDIU) ? ALUB_SEXT : ALUB_ZEXT;
        case (cls)
          CLS_ORI: ctrl.alu_op = ALU_OR;
          CLS_LUI: ctrl.alu_op = ALU_LUI;
          default: ctrl.alu_op = ALU_ADD;
        endcase
      end
      S_WB_REG: begin
        ctrl.gpr_we    = 1'b1;
        ctrl.sel_wdata = WDATA_ALUOUT;
        ctrl.sel_wreg  = is_rtype(cls) ? WREG_RD : WREG_RT;
      end
      S_MEM_ADDR: begin
        ctrl.sel_alua = ALUA_RS;
        ctrl.sel_alub = ALUB_SEXT;
        ctrl.alu_op   = ALU_ADD;
      end
      S_MEM_RD: ctrl.sel_addr = ADDR_ALUOUT;
      S_MEM_WB: begin
        ctrl.gpr_we    = 1'b1;
        ctrl.sel_wdata = WDATA_MDR;
        ctrl.sel_wreg  = WREG_RT;
      end
      S_MEM_WR: begin
        ctrl.sel_addr = ADDR_ALUOUT;
        ctrl.dmem_we  = 1'b1;
      end
      S_BRANCH: begin
        ctrl.sel_alua = ALUA_RS;
        ctrl.sel_alub = ALUB_RT;
        ctrl.alu_op   = ALU_SUB;
        ctrl.npc_sel  = NPC_ALU;
      end
      S_JUMP: begin
        ctrl.pc_we   = 1'b1;
        ctrl.npc_sel = NPC_JMP;
      end
      default: ctrl = CTRL_IDLE;
    endcase
  end

  // Reset drops FETCH's enables immediately; BRANCH takes pc_we from the live zero flag
  assign pc_we     = ~rst & (ctrl.pc_we | ((state == S_BRANCH) & zero));
  assign ir_we     = ~rst & ctrl.ir_we;
  assign gpr_we    = ~rst & ctrl.gpr_we;
  assign dmem_we   = ~rst & ctrl.dmem_we;
  assign npc_sel   = ctrl.npc_sel;
  assign sel_addr  = ctrl.sel_addr;
  assign sel_alua  = ctrl.sel_alua;
  assign sel_alub  = ctrl.sel_alub;
  assign sel_wdata = ctrl.sel_wdata;
  assign sel_wreg  = ctrl.sel_wreg;
  assign alu_op    = ctrl.alu_op;

`ifdef MC_ILLEGAL_TRAP_EN
  assign illegal = (state == S_HALT);
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: directed instructions, reset abort, illegal op, random stream.
// Honours MC_ILLEGAL_TRAP_EN the same way the design does.
module tb_mc_ctrl_fsm;
  import mc_ctrl_pkg::*;

  logic       clk;
  logic       rst;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pc_we, ir_we, gpr_we, dmem_we;
  logic [1:0] npc_sel, sel_addr, sel_alua, sel_wdata, sel_wreg;
  logic [3:0] sel_alub;
  logic [2:0] alu_op;
  logic       illegal;

  int checks   = 0;
  int failures = 0;

  mc_ctrl_fsm dut (
    .clk       (clk),
    .rst       (rst),
    .op        (op),
    .funct     (funct),
    .zero      (zero),
    .pc_we     (pc_we),
    .ir_we     (ir_we),
    .gpr_we    (gpr_we),
    .dmem_we   (dmem_we),
    .npc_sel   (npc_sel),
    .sel_addr  (sel_addr),
    .sel_alua  (sel_alua),
    .sel_alub  (sel_alub),
    .sel_wdata (sel_wdata),
    .sel_wreg  (sel_wreg),
    .alu_op    (alu_op),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One expected cycle: enables {pc,ir,gpr,dmem}, pc_we-follows-zero flag,
  // illegal, and the select word {npc,addr,alua,alub,wdata,wreg,alu_op} with a care mask.
  typedef struct packed {
    logic [3:0]  en;
    logic        br;
    logic        ill;
    logic [16:0] sel;
    logic [16:0] care;
  } step_t;

  step_t q[$];

  localparam logic [1:0] X2  = 2'b00;
  localparam logic [3:0] X4  = 4'b0000;
  localparam logic [3:0] EN0 = 4'b0000;

  // Zero-valued selects and a negative alu code mean "not constrained in this step"
  function automatic step_t st(input logic [3:0] en, input logic br, input logic ill,
                               input logic [1:0] npc, input logic [1:0] addr,
                               input logic [1:0] alua, input logic [3:0] alub,
                               input logic [1:0] wdata, input logic [1:0] wreg,
                               input int alu);
    step_t s;
    s.en   = en;
    s.br   = br;
    s.ill  = ill;
    s.sel  = {npc, addr, alua, alub, wdata, wreg, (alu < 0) ? 3'd0 : 3'(alu)};
    s.care = {{2{npc != X2}}, {2{addr != X2}}, {2{alua != X2}}, {4{alub != X4}},
              {2{wdata != X2}}, {2{wreg != X2}}, {3{alu >= 0}}};
    return s;
  endfunction

  // Expected cycle-by-cycle behaviour of one instruction, straight from the step table
  task automatic build(input logic [5:0] o, input logic [5:0] f);
    int alu;
    q.delete();
    q.push_back(st(4'b1100, 1'b0, 1'b0, 2'b01, 2'b01, 2'b01, 4'b0010, X2, X2, int'(ALU_ADD)));
    q.push_back(st(EN0, 1'b0, 1'b0, X2, X2, X2, X4, X2, X2, -1));
    if (o == 6'h00 && (f == 6'h21 || f == 6'h23)) begin
      alu = (f == 6'h23) ? int'(ALU_SUB) : int'(ALU_ADD);
      q.push_back(st(EN0, 1'b0, 1'b0, X2, X2, 2'b10, 4'b0001, X2, X2, alu));
      q.push_back(st(4'b0010, 1'b0, 1'b0, X2, X2, X2, X4, 2'b01, 2'b10, -1));
    end else if (o == 6'h0D || o == 6'h0F || o == 6'h09) begin
      alu = (o == 6'h0D) ? int'(ALU_OR) : (o == 6'h0F) ? int'(ALU_LUI) : int'(ALU_ADD);
      q.push_back(st(EN0, 1'b0, 1'b0, X2, X2, 2'b10, (o == 6'h09) ? 4'b0100 : 4'b1000,
                     X2, X2, alu));
      q.push_back(st(4'b0010, 1'b0, 1'b0, X2, X2, X2, X4, 2'b01, 2'b01, -1));
    end else if (o == 6'h23 || o == 6'h2B) begin
      q.push_back(st(EN0, 1'b0, 1'b0, X2, X2, 2'b10, 4'b0100, X2, X2, int'(ALU_ADD)));
      if (o == 6'h23) begin
        q.push_back(st(EN0, 1'b0, 1'b0, X2, 2'b10, X2, X4, X2, X2, -1));
        q.push_back(st(4'b0010, 1'b0, 1'b0, X2, X2, X2, X4, 2'b10, 2'b01, -1));
      end else begin
        q.push_back(st(4'b0001, 1'b0, 1'b0, X2, 2'b10, X2, X4, X2, X2, -1));
      end
    end else if (o == 6'h04) begin
      q.push_back(st(EN0, 1'b1, 1'b0, 2'b01, X2, 2'b10, 4'b0001, X2, X2, int'(ALU_SUB)));
    end else if (o == 6'h02) begin
      q.push_back(st(4'b1000, 1'b0, 1'b0, 2'b10, X2, X2, X4, X2, X2, -1));
    end
  endtask

  task automatic check(input step_t s, input string tag, input int idx);
    logic [3:0]  en_o;
    logic [3:0]  en_x;
    logic [16:0] sel_o;
    en_o  = {pc_we, ir_we, gpr_we, dmem_we};
    en_x  = s.en | {s.br & zero, 3'b000};
    sel_o = {npc_sel, sel_addr, sel_alua, sel_alub, sel_wdata, sel_wreg, alu_op};
    checks++;
    assert (en_o === en_x) else begin
      failures++;
      $error("FAIL %s[%0d] enables observed=%b expected=%b", tag, idx, en_o, en_x);
    end
    checks++;
    assert ((sel_o & s.care) === (s.sel & s.care)) else begin
      failures++;
      $error("FAIL %s[%0d] selects observed=%h expected=%h mask=%h",
             tag, idx, sel_o, s.sel, s.care);
    end
    checks++;
    assert (illegal === s.ill) else begin
      failures++;
      $error("FAIL %s[%0d] illegal observed=%b expected=%b", tag, idx, illegal, s.ill);
    end
    checks++;
    assert ($onehot(npc_sel) && $onehot(sel_addr) && $onehot(sel_alua) &&
            $onehot(sel_alub) && $onehot(sel_wdata) && $onehot(sel_wreg)) else begin
      failures++;
      $error("FAIL %s[%0d] onehot observed=%b_%b_%b_%b_%b_%b expected=one-hot each",
             tag, idx, npc_sel, sel_addr, sel_alua, sel_alub, sel_wdata, sel_wreg);
    end
  endtask

  // Play the queued steps, one clock each; zmode<0 randomises zero per cycle
  task automatic run_q(input string tag, input int zmode);
    step_t s;
    int    i;
    i = 0;
    while (q.size() > 0) begin
      s = q.pop_front();
      zero = (zmode < 0) ? 1'($urandom) : 1'(zmode);
      @(negedge clk);
      check(s, tag, i);
      @(posedge clk);
      #1;
      i++;
    end
  endtask

  task automatic do_instr(input logic [5:0] o, input logic [5:0] f, input string tag,
                          input int zmode);
    op    = o;
    funct = f;
    build(o, f);
    run_q(tag, zmode);
  endtask

  initial begin
    rst   = 1'b1;
    op    = 6'h00;
    funct = 6'h00;
    zero  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check(st(EN0, 1'b0, 1'b0, X2, X2, X2, X4, X2, X2, -1), "reset", 0);
    @(posedge clk);
    #1 rst = 1'b0;

    do_instr(6'h00, 6'h21, "addu", -1);
    do_instr(6'h00, 6'h23, "subu", -1);
    do_instr(6'h23, 6'h00, "lw", -1);
    do_instr(6'h2B, 6'h00, "sw", -1);
    do_instr(6'h04, 6'h00, "beq_taken", 1);
    do_instr(6'h04, 6'h00, "beq_not_taken", 0);
    do_instr(6'h02, 6'h00, "j", -1);
    do_instr(6'h0D, 6'h3F, "ori", -1);
    do_instr(6'h0F, 6'h00, "lui", -1);
    do_instr(6'h09, 6'h21, "addiu", -1);

    // Reset during the address step of a store: the store must never write
    op    = 6'h2B;
    funct = 6'h00;
    build(6'h2B, 6'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check(q.pop_front(), "sw_abort", i);
      if (i < 2) begin
        @(posedge clk);
        #1;
      end
    end
    #1 rst = 1'b1;
    #1 check(st(EN0, 1'b0, 1'b0, X2, X2, X2, X4, X2, X2, -1), "rst_hold", 0);
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      check(st(EN0, 1'b0, 1'b0, X2, X2, X2, X4, X2, X2, -1), "rst_hold", i);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    do_instr(6'h00, 6'h21, "after_rst", -1);

`ifdef MC_ILLEGAL_TRAP_EN
    do_instr(6'h3F, 6'h00, "illegal", -1);
    for (int i = 0; i < 10; i++) begin
      zero = 1'($urandom);
      @(negedge clk);
      check(st(EN0, 1'b0, 1'b1, X2, X2, X2, X4, X2, X2, -1), "halt", i);
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1 check(st(EN0, 1'b0, 1'b0, X2, X2, X2, X4, X2, X2, -1), "halt_rst", 0);
    @(posedge clk);
    #1 rst = 1'b0;
`else
    do_instr(6'h3F, 6'h00, "illegal_op", -1);
    do_instr(6'h00, 6'h20, "illegal_funct", -1);
`endif
    do_instr(6'h23, 6'h00, "lw_after_illegal", -1);

    // Random instruction stream
    for (int n = 0; n < 1000; n++) begin
      logic [5:0] o;
      logic [5:0] f;
      f = 6'($urandom);
      case ($urandom_range(0, 10))
        0:       begin o = 6'h00; f = 6'h21; end
        1:       begin o = 6'h00; f = 6'h23; end
        2:       o = 6'h0D;
        3:       o = 6'h0F;
        4:       o = 6'h09;
        5:       o = 6'h23;
        6:       o = 6'h2B;
        7:       o = 6'h04;
        8:       o = 6'h02;
`ifdef MC_ILLEGAL_TRAP_EN
        default: o = 6'h23;
`else
        default: o = 6'($urandom);
`endif
      endcase
      do_instr(o, f, "random", -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
